// File: rtl/dlx_fetch_stage_pkg.sv
// dlx_fetch_stage_pkg: shared word width, NOP encoding and fetch FSM states.
package dlx_fetch_stage_pkg;
    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;
    localparam word_t NOP = 32'd0;
    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;
endpackage

// File: rtl/dlx_fetch_stage_if.sv
// dlx_fetch_stage_if: ROM, control and IF/ID bundle of the fetch stage.
interface dlx_fetch_stage_if import dlx_fetch_stage_pkg::*; #(parameter int CNT_W = 16) ();
    word_t            pc_o;
    word_t            inst_i;
    logic             stall_i;
    logic             branch_taken_i;
    word_t            branch_target_i;
    logic             halt_i;
    word_t            ifid_inst_o;
    word_t            ifid_npc_o;
    logic             ifid_valid_o;
    logic [CNT_W-1:0] fetch_cnt_o;
    logic [1:0]       state_o;
    modport master (
        input  inst_i, stall_i, branch_taken_i, branch_target_i, halt_i,
        output pc_o, ifid_inst_o, ifid_npc_o, ifid_valid_o, fetch_cnt_o, state_o
    );
    modport slave (
        output inst_i, stall_i, branch_taken_i, branch_target_i, halt_i,
        input  pc_o, ifid_inst_o, ifid_npc_o, ifid_valid_o, fetch_cnt_o, state_o
    );
endinterface

// File: rtl/dlx_ifid_reg.sv
// dlx_ifid_reg: IF/ID pipeline register; flush clears only the valid bit.
module dlx_ifid_reg import dlx_fetch_stage_pkg::*; (
    input  logic  clk_i,
    input  logic  reset_i,
    input  logic  i_load,
    input  logic  i_flush,
    input  word_t i_inst,
    input  word_t i_npc,
    output word_t o_inst,
    output word_t o_npc,
    output logic  o_valid
);
    word_t r_inst, r_npc;
    logic  r_valid;
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_inst  <= NOP;
            r_npc   <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_inst  <= i_inst;
            r_npc   <= i_npc;
            r_valid <= 1'b1;
        end
    end
    assign o_inst  = r_inst;
    assign o_npc   = r_npc;
    assign o_valid = r_valid;
endmodule

// File: rtl/dlx_fetch_stage.sv
// dlx_fetch_stage: DLX instruction fetch with BOOT/RUN/HALTED control,
// branch redirect, stall hold and a saturating fetch counter.
module dlx_fetch_stage import dlx_fetch_stage_pkg::*; #(
    parameter word_t RESET_PC = 32'd0,
    parameter int    CNT_W    = 16
) (
    input logic               clk_i,
    input logic               reset_i,
    dlx_fetch_stage_if.master bus
);
    state_t           r_state, w_next;
    word_t            r_pc, w_pc_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_run, w_load, w_flush;
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) r_state <= S_BOOT;
        else          r_state <= w_next;
    end
    // Halt outranks branch, branch outranks stall; the encoding 2'd3 falls back to BOOT.
    always_comb begin
        w_run    = r_state == S_RUN;
        w_flush  = w_run && (bus.halt_i || bus.branch_taken_i);
        w_load   = w_run && !bus.halt_i && !bus.branch_taken_i && !bus.stall_i;
        w_next   = r_state == S_BOOT   ? S_RUN :
                   w_run               ? (bus.halt_i ? S_HALTED : S_RUN) :
                   r_state == S_HALTED ? S_HALTED : S_BOOT;
        w_pc_nxt = (w_run && !bus.halt_i && bus.branch_taken_i) ? bus.branch_target_i :
                   w_load ? r_pc + 32'd1 : r_pc;
    end
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_pc  <= RESET_PC;
            r_cnt <= '0;
        end else begin
            r_pc <= w_pc_nxt;
            if (w_load && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
        end
    end
    dlx_ifid_reg u_ifid (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_inst  (bus.inst_i),
        .i_npc   (r_pc + 32'd1),
        .o_inst  (bus.ifid_inst_o),
        .o_npc   (bus.ifid_npc_o),
        .o_valid (bus.ifid_valid_o)
    );
    assign bus.pc_o        = r_pc;
    assign bus.fetch_cnt_o = r_cnt;
    assign bus.state_o     = r_state;
endmodule

// File: tb/tb_dlx_fetch_stage.sv
// tb_dlx_fetch_stage: directed and random checks of two fetch stages
// (16-bit and 4-bit counters) against a cycle-level behavioural model.
module tb_dlx_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, br = 1'b0, halt = 1'b0;
    logic [31:0] tgt = '0;
    int          total = 0, bad = 0;
    logic [1:0]  m_state;
    logic [31:0] m_pc, m_inst, m_npc;
    logic        m_valid;
    int          m_cnt;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    dlx_fetch_stage_if #(.CNT_W(16)) b16 ();
    dlx_fetch_stage_if #(.CNT_W(4))  b4 ();
    assign b16.inst_i = rom(b16.pc_o);
    assign b4.inst_i  = rom(b4.pc_o);
    assign b16.stall_i = stall;
    assign b4.stall_i  = stall;
    assign b16.branch_taken_i = br;
    assign b4.branch_taken_i  = br;
    assign b16.branch_target_i = tgt;
    assign b4.branch_target_i  = tgt;
    assign b16.halt_i = halt;
    assign b4.halt_i  = halt;

    dlx_fetch_stage #(.RESET_PC(32'd0), .CNT_W(16)) u16 (.clk_i(clk), .reset_i(rst_n), .bus(b16.master));
    dlx_fetch_stage #(.RESET_PC(32'd0), .CNT_W(4))  u4  (.clk_i(clk), .reset_i(rst_n), .bus(b4.master));

    function automatic logic [151:0] dut_v();
        return {b16.pc_o, b16.ifid_inst_o, b16.ifid_npc_o, b16.ifid_valid_o, b16.fetch_cnt_o,
                b4.fetch_cnt_o, b16.state_o, b4.pc_o, b4.ifid_valid_o};
    endfunction

    function automatic logic [151:0] exp_v();
        logic [15:0] c16;
        logic [3:0]  c4;
        c16 = m_cnt > 65535 ? 16'hFFFF : m_cnt[15:0];
        c4  = m_cnt > 15 ? 4'hF : m_cnt[3:0];
        return {m_pc, m_inst, m_npc, m_valid, c16, c4, m_state, m_pc, m_valid};
    endfunction

    task automatic model_reset();
        m_state = 2'd0; m_pc = 32'd0; m_inst = 32'd0; m_npc = 32'd0; m_valid = 1'b0; m_cnt = 0;
    endtask

    // One clock edge of the reference, then advance the DUTs and settle.
    task automatic step();
        if (!rst_n) model_reset();
        else if (m_state == 2'd0) m_state = 2'd1;
        else if (m_state == 2'd1) begin
            if (halt) begin
                m_state = 2'd2; m_valid = 1'b0;
            end else if (br) begin
                m_pc = tgt; m_valid = 1'b0;
            end else if (!stall) begin
                m_inst = rom(m_pc); m_npc = m_pc + 32'd1; m_valid = 1'b1;
                m_pc = m_pc + 32'd1; m_cnt++;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic h, input logic b, input logic s, input logic [31:0] t);
        halt = h; br = b; stall = s; tgt = t;
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        drive(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (dut_v() !== exp_v()) begin bad++; $display("FAIL reset_hold c%0d got=%h exp=%h", i, dut_v(), exp_v()); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_boot_seq();
        logic [31:0] pcs [4] = '{32'd0, 32'd1, 32'd2, 32'd3};
        total++;
        if (b16.state_o !== 2'd0 || b16.pc_o !== 32'd0) begin bad++; $display("FAIL boot_state got=%0d/%h exp=0/0", b16.state_o, b16.pc_o); end
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (b16.pc_o !== pcs[i]) begin bad++; $display("FAIL boot_pc c%0d got=%h exp=%h", i, b16.pc_o, pcs[i]); end
            total++;
            if (dut_v() !== exp_v()) begin bad++; $display("FAIL boot_seq c%0d got=%h exp=%h", i, dut_v(), exp_v()); end
        end
        total++;
        if (b16.ifid_npc_o !== 32'd3 || b16.ifid_valid_o !== 1'b1) begin bad++; $display("FAIL boot_npc got=%h/%b exp=3/1", b16.ifid_npc_o, b16.ifid_valid_o); end
    endtask

    task automatic test_branch();
        while (m_pc != 32'd7) step();
        drive(0, 1, 0, 32'd15);
        step();
        total++;
        if (b16.pc_o !== 32'd15 || b16.ifid_valid_o !== 1'b0) begin bad++; $display("FAIL branch_redirect got=%h/%b exp=f/0", b16.pc_o, b16.ifid_valid_o); end
        drive(0, 0, 0, 0);
        step();
        total++;
        if (b16.ifid_inst_o !== rom(32'd15) || b16.ifid_npc_o !== 32'd16 || b16.ifid_valid_o !== 1'b1) begin
            bad++; $display("FAIL branch_fetch got=%h/%h exp=%h/10", b16.ifid_inst_o, b16.ifid_npc_o, rom(32'd15));
        end
    endtask

    task automatic test_stall();
        logic [151:0] held;
        int           cnt0;
        drive(0, 1, 0, 32'd4);
        step();
        drive(0, 0, 1, 0);
        held = exp_v();
        cnt0 = m_cnt;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (dut_v() !== held || b16.pc_o !== 32'd4 || m_cnt != cnt0) begin bad++; $display("FAIL stall_hold c%0d got=%h exp=%h", i, dut_v(), held); end
        end
        drive(0, 0, 0, 0);
        step();
        total++;
        if (b16.ifid_inst_o !== rom(32'd4) || b16.ifid_npc_o !== 32'd5 || dut_v() !== exp_v()) begin
            bad++; $display("FAIL stall_resume got=%h exp=%h", dut_v(), exp_v());
        end
    endtask

    task automatic test_stall_branch();
        drive(0, 1, 1, 32'd2);
        step();
        total++;
        if (b16.pc_o !== 32'd2 || b16.ifid_valid_o !== 1'b0) begin bad++; $display("FAIL stall_branch got=%h/%b exp=2/0", b16.pc_o, b16.ifid_valid_o); end
        drive(0, 0, 0, 0);
    endtask

    task automatic test_wrap();
        drive(0, 1, 0, 32'hFFFF_FFFF);
        step();
        drive(0, 0, 0, 0);
        step();
        total++;
        if (b16.pc_o !== 32'd0 || b16.ifid_npc_o !== 32'd0 || b16.ifid_inst_o !== rom(32'hFFFF_FFFF)) begin
            bad++; $display("FAIL wrap got=%h/%h exp=0/0", b16.pc_o, b16.ifid_npc_o);
        end
        total++;
        if (dut_v() !== exp_v()) begin bad++; $display("FAIL wrap_model got=%h exp=%h", dut_v(), exp_v()); end
    endtask

    task automatic test_halt();
        drive(0, 1, 0, 32'd9);
        step();
        drive(1, 0, 0, 0);
        step();
        total++;
        if (b16.state_o !== 2'd2 || b16.pc_o !== 32'd9 || b16.ifid_valid_o !== 1'b0) begin
            bad++; $display("FAIL halt_enter got=%0d/%h/%b exp=2/9/0", b16.state_o, b16.pc_o, b16.ifid_valid_o);
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), $urandom);
            step();
            total++;
            if (dut_v() !== exp_v() || b16.pc_o !== 32'd9) begin bad++; $display("FAIL halt_frozen c%0d got=%h exp=%h", i, dut_v(), exp_v()); end
        end
        async_reset();
        total++;
        if (b16.state_o !== 2'd0 || b16.pc_o !== 32'd0 || dut_v() !== exp_v()) begin bad++; $display("FAIL halt_reset got=%h exp=%h", dut_v(), exp_v()); end
        drive(0, 0, 0, 0);
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_saturate();
        drive(0, 0, 0, 0);
        for (int i = 0; i < 22; i++) step();
        total++;
        if (b4.fetch_cnt_o !== 4'hF || b16.fetch_cnt_o !== 16'(m_cnt)) begin
            bad++; $display("FAIL saturate got=%h/%h exp=f/%h", b4.fetch_cnt_o, b16.fetch_cnt_o, 16'(m_cnt));
        end
    endtask

    task automatic test_random();
        logic [31:0] t;
        for (int i = 0; i < 500; i++) begin
            t = $urandom_range(3) == 0 ? 32'hFFFF_FFFF - $urandom_range(2) : $urandom;
            drive($urandom_range(40) == 0, $urandom_range(4) == 0, $urandom_range(3) == 0, t);
            if ((m_state == 2'd2 && $urandom_range(3) == 0) || $urandom_range(150) == 0) begin
                async_reset();
                total++;
                if (dut_v() !== exp_v()) begin bad++; $display("FAIL rand_async c%0d got=%h exp=%h", i, dut_v(), exp_v()); end
                step();
                rst_n = 1'b1;
            end else
                step();
            total++;
            if (dut_v() !== exp_v()) begin bad++; $display("FAIL rand c%0d got=%h exp=%h", i, dut_v(), exp_v()); end
        end
    endtask

    initial begin
        test_reset();
        test_boot_seq();
        test_branch();
        test_stall();
        test_stall_branch();
        test_wrap();
        test_halt();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
